// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator for a 640x480 @ 60 Hz VGA display running from the
// 50 MHz system clock. A clock divider produces a pixel-enable strobe. The
// horizontal and vertical position counters advance on that strobe. Every
// output is registered on the same edge that moves the counters, so the
// coordinates, blanking and sync signals always describe the same pixel.
//
// Ports
//   clk           : system clock (single clock domain)
//   rst_n         : asynchronous reset, active low
//   x, y          : current pixel position (10 bits each)
//   active_pixels : high inside the visible 640x480 area
//   VGA_BLANK_N   : copy of active_pixels for the DAC
//   VGA_HS        : horizontal sync, active low
//   VGA_VS        : vertical sync, active low
//   VGA_CLK       : pixel clock to the DAC; rises in the middle of a pixel
//   pix_en        : one-clk strobe, high in the cycle after each pixel advance
//   frame_tick    : one-clk pulse when the position enters (0, V_ACTIVE)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active_pixels,
   output logic       VGA_BLANK_N,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_CLK,
   output logic       pix_en,
   output logic       frame_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] D_HALF = DW'(CLK_DIV / 2);

   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] d_r;
   logic [DW-1:0] d_next_s;
   logic          adv_s;
   logic [9:0]    hc_r;
   logic [9:0]    vc_r;
   logic [9:0]    hc_next_s;
   logic [9:0]    vc_next_s;

   // Next-state logic for the divider and the position counters.
   always_comb begin
      adv_s     = (d_r == D_LAST);
      d_next_s  = d_r;
      hc_next_s = hc_r;
      vc_next_s = vc_r;
      if (adv_s) begin
         d_next_s = {DW{1'b0}};
         // Explicit compares against the last value; no reliance on overflow.
         if (hc_r == H_LAST) begin
            hc_next_s = 10'd0;
            if (vc_r == V_LAST) begin
               vc_next_s = 10'd0;
            end else begin
               vc_next_s = vc_r + 10'd1;
            end
         end else begin
            hc_next_s = hc_r + 10'd1;
            vc_next_s = vc_r;
         end
      end else begin
         d_next_s  = d_r + DW'(1);
         hc_next_s = hc_r;
         vc_next_s = vc_r;
      end
   end

   // Divider and position counter state. The counters reset to the last
   // position so the first advance after reset lands exactly on (0,0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_r  <= {DW{1'b0}};
         hc_r <= H_LAST;
         vc_r <= V_LAST;
      end else begin
         d_r  <= d_next_s;
         hc_r <= hc_next_s;
         vc_r <= vc_next_s;
      end
   end

   // Registered outputs, all decoded from the post-advance position so that
   // coordinates, blanking and syncs change together on the pixel edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x             <= 10'd0;
         y             <= 10'd0;
         active_pixels <= 1'b0;
         VGA_BLANK_N   <= 1'b0;
         VGA_HS        <= 1'b1;
         VGA_VS        <= 1'b1;
         VGA_CLK       <= 1'b0;
         pix_en        <= 1'b0;
         frame_tick    <= 1'b0;
      end else begin
         // Built from the next divider value: falls on the advance edge and
         // rises CLK_DIV/2 clocks later, i.e. mid-pixel.
         VGA_CLK    <= (d_next_s >= D_HALF);
         pix_en     <= adv_s;
         frame_tick <= adv_s && (hc_next_s == 10'd0) && (vc_next_s == V_ACT);
         if (adv_s) begin
            x             <= hc_next_s;
            y             <= vc_next_s;
            active_pixels <= (hc_next_s < H_ACT) && (vc_next_s < V_ACT);
            VGA_BLANK_N   <= (hc_next_s < H_ACT) && (vc_next_s < V_ACT);
            VGA_HS        <= !((hc_next_s >= HS_START) && (hc_next_s < HS_END));
            VGA_VS        <= !((vc_next_s >= VS_START) && (vc_next_s < VS_END));
         end else begin
            x             <= x;
            y             <= y;
            active_pixels <= active_pixels;
            VGA_BLANK_N   <= VGA_BLANK_N;
            VGA_HS        <= VGA_HS;
            VGA_VS        <= VGA_VS;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen, run with a shrunken raster so that
// several whole frames fit in a short run. Expected outputs come from a
// model that derives everything from the number of clock edges since reset
// release; they are queued when a step is driven and popped after the edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int CD  = 2;
   localparam int HA  = 8;
   localparam int HFP = 2;
   localparam int HSY = 3;
   localparam int HBP = 2;
   localparam int VA  = 6;
   localparam int VFP = 2;
   localparam int VSY = 2;
   localparam int VBP = 3;
   localparam int HT  = HA + HFP + HSY + HBP;
   localparam int VT  = VA + VFP + VSY + VBP;
   localparam int LINE_CLK  = HT * CD;
   localparam int FRAME_CLK = HT * VT * CD;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       act;
      logic       blank;
      logic       hs;
      logic       vs;
      logic       vclk;
      logic       pen;
      logic       ft;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [9:0] x;
   logic [9:0] y;
   logic       active_pixels;
   logic       VGA_BLANK_N;
   logic       VGA_HS;
   logic       VGA_VS;
   logic       VGA_CLK;
   logic       pix_en;
   logic       frame_tick;

   int   errors;
   int   checks;
   int   e_cnt;
   int   hs_low;
   int   vs_low;
   exp_t exp_q[$];
   exp_t last_exp;
   int   tick_q[$];

   vga_timing_gen #(
      .CLK_DIV (CD),
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .x            (x),
      .y            (y),
      .active_pixels(active_pixels),
      .VGA_BLANK_N  (VGA_BLANK_N),
      .VGA_HS       (VGA_HS),
      .VGA_VS       (VGA_VS),
      .VGA_CLK      (VGA_CLK),
      .pix_en       (pix_en),
      .frame_tick   (frame_tick)
   );

   // 10 ns system clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs after e edges since reset release (e = 0: in reset).
   function automatic exp_t model(input int e);
      exp_t r;
      int   k;
      int   idx;
      int   xx;
      int   yy;
      r = '{x: 10'd0, y: 10'd0, act: 1'b0, blank: 1'b0, hs: 1'b1, vs: 1'b1,
            vclk: 1'b0, pen: 1'b0, ft: 1'b0};
      r.vclk = ((e % CD) >= (CD / 2));
      r.pen  = (e > 0) && ((e % CD) == 0);
      k = e / CD;
      if (k >= 1) begin
         idx     = k - 1;
         xx      = idx % HT;
         yy      = (idx / HT) % VT;
         r.x     = 10'(xx);
         r.y     = 10'(yy);
         r.act   = (xx < HA) && (yy < VA);
         r.blank = r.act;
         r.hs    = !((xx >= HA + HFP) && (xx < HA + HFP + HSY));
         r.vs    = !((yy >= VA + VFP) && (yy < VA + VFP + VSY));
         r.ft    = r.pen && (xx == 0) && (yy == VA);
      end
      return r;
   endfunction

   function automatic exp_t observed();
      exp_t r;
      r = '{x: x, y: y, act: active_pixels, blank: VGA_BLANK_N, hs: VGA_HS,
            vs: VGA_VS, vclk: VGA_CLK, pen: pix_en, ft: frame_tick};
      return r;
   endfunction

   task automatic chk_out(input string tag, input exp_t exp);
      exp_t obs;
      obs = observed();
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s e=%0d observed x=%0d y=%0d act=%b blank=%b hs=%b vs=%b vclk=%b pen=%b ft=%b expected x=%0d y=%0d act=%b blank=%b hs=%b vs=%b vclk=%b pen=%b ft=%b",
                tag, e_cnt, obs.x, obs.y, obs.act, obs.blank, obs.hs, obs.vs, obs.vclk, obs.pen, obs.ft,
                exp.x, exp.y, exp.act, exp.blank, exp.hs, exp.vs, exp.vclk, exp.pen, exp.ft);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock edge: queue the expectation, let the edge happen, compare.
   task automatic step(input string tag);
      exp_t exp;
      if (rst_n) e_cnt++;
      exp_q.push_back(model(rst_n ? e_cnt : 0));
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      last_exp = exp;
      chk_out(tag, exp);
      if (rst_n) begin
         if (e_cnt >= 1 && e_cnt <= LINE_CLK && VGA_HS === 1'b0) hs_low++;
         if (e_cnt >= 1 && e_cnt <= FRAME_CLK && VGA_VS === 1'b0) vs_low++;
         if (frame_tick === 1'b1) tick_q.push_back(e_cnt);
      end
   endtask

   initial begin
      bit found;
      errors = 0;
      checks = 0;
      e_cnt  = 0;
      hs_low = 0;
      vs_low = 0;

      // Reset held for 5 cycles.
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) step("reset_hold");

      // Release away from the clock edge; first pixel on edge CD.
      @(negedge clk);
      rst_n = 1'b1;
      step("first_edge");
      chk_int("no_pix_en_edge1", int'(pix_en), 0);
      step("second_edge");
      chk_int("pix_en_edge2", int'(pix_en), 1);
      chk_int("first_pixel_active", int'(active_pixels), 1);

      // Three full frames plus margin, every edge compared.
      for (int i = 0; i < 3 * FRAME_CLK + 128; i++) step("raster");
      chk_int("hs_low_clk_per_line", hs_low, HSY * CD);
      chk_int("vs_low_clk_per_frame", vs_low, VSY * HT * CD);
      chk_int("frame_tick_count", tick_q.size(), 3);
      if (tick_q.size() == 3) begin
         chk_int("first_tick_edge", tick_q[0], (VA * HT + 1) * CD);
         chk_int("tick_spacing_1", tick_q[1] - tick_q[0], FRAME_CLK);
         chk_int("tick_spacing_2", tick_q[2] - tick_q[1], FRAME_CLK);
      end

      // Run to a mid-frame position, then reset asynchronously.
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME_CLK && !found; i++) begin
         step("seek_mid");
         if (last_exp.pen && last_exp.x == 10'd5 && last_exp.y == 10'd3) found = 1'b1;
      end
      chk_int("reached_mid_frame", int'(found), 1);
      rst_n = 1'b0;
      #2;
      exp_q.push_back(model(0));
      chk_out("async_reset", exp_q.pop_front());
      for (int i = 0; i < 3; i++) step("mid_reset_hold");

      @(negedge clk);
      rst_n = 1'b1;
      e_cnt = 0;
      step("restart_edge1");
      step("restart_edge2");
      chk_int("restart_pix_en", int'(pix_en), 1);
      chk_int("restart_x", int'(x), 0);
      chk_int("restart_y", int'(y), 0);
      for (int i = 0; i < 2 * LINE_CLK; i++) step("restart_run");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the 50 MHz system clock and feeds the pixel coordinate, active-video and sync signals to the downstream frame renderer. The renderer colours the pixel at `x`/`y`; this block owns the pixel-enable divider, the horizontal and vertical counters, sync/blank generation and a once-per-frame tick. Game logic uses that tick to update player and lava state during vertical blanking.

## Interface
- `CLK_DIV`, 2: system clocks per pixel; must be ≥ 2.
- `H_ACTIVE`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal segment lengths in pixels. H_TOTAL = 800.
- `V_ACTIVE`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical segment lengths in lines. V_TOTAL = 525.
- `clk` input 1: system clock, 50 MHz. Single clock domain.
- `rst_n` input 1: asynchronous reset, active-low.
- `x` output 10: current horizontal position, 0..H_TOTAL-1.
- `y` output 10: current vertical position, 0..V_TOTAL-1.
- `active_pixels` output 1: high when x < H_ACTIVE and y < V_ACTIVE.
- `VGA_BLANK_N` output 1: equal to `active_pixels`.
- `VGA_HS` output 1: horizontal sync, active-low.
- `VGA_VS` output 1: vertical sync, active-low.
- `VGA_CLK` output 1: pixel clock sent to the DAC.
- `pix_en` output 1: one-`clk` strobe marking each pixel advance.
- `frame_tick` output 1: one-`clk` pulse at the start of vertical blanking.

## Operation
- **Divider `d`:**
  - Counts 0..CLK_DIV-1 and wraps.
  - `pix_en` = (d == CLK_DIV-1).
- **Position counters `hc`/`vc`:**
  - Advance only on `clk` edges where `pix_en` is high.
  - `hc` wraps H_TOTAL-1 → 0. When `hc` wraps, `vc` increments, wrapping V_TOTAL-1 → 0.
- **Registered outputs:**
  - All outputs are registered and update on the same `pix_en` edge as the counters.
  - `x`/`y` equal the new `hc`/`vc`.
  - `VGA_HS` = 0 iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC, i.e. x in 656..751 at the defaults.
  - `VGA_VS` = 0 iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC, i.e. y in 490..491 at the defaults.
- **`frame_tick`:**
  - High for exactly one `clk`, on the edge where the position becomes (0, V_ACTIVE).
  - Low otherwise.
- **`VGA_CLK`:**
  - Registered; high while d ≥ CLK_DIV/2 (integer division).
  - Its rising edge falls mid-pixel, so data is stable on both sides of it.
- **Reset (asynchronous, any time including mid-frame):**
  - `d` = 0; `hc` = H_TOTAL-1; `vc` = V_TOTAL-1.
  - `x` = 0, `y` = 0, `active_pixels` = 0, `VGA_BLANK_N` = 0.
  - `VGA_HS` = 1, `VGA_VS` = 1, `VGA_CLK` = 0, `frame_tick` = 0, `pix_en` = 0.
- **Width rules:**
  - Counters are 10 bits. Compare against totals minus one; never rely on natural overflow.
  - Parameters are local arithmetic only; no runtime reconfiguration.

## Timing
- **First pixel:** after `rst_n` rises, the first `pix_en` occurs on the CLK_DIV-th `clk` edge. On that edge the outputs become (0,0) with `active_pixels` = 1, so no pixel of the first frame is skipped.
- **Pixel period:** CLK_DIV `clk` cycles, 40 ns at the defaults.
- **Line period:** H_TOTAL × CLK_DIV = 1600 `clk`.
- **Frame period:** 525 × 1600 = 840000 `clk`, giving 59.52 Hz.
- **Renderer alignment:** latency from counter to outputs is zero relative to the `pix_en` edge. The renderer is combinational and sees `x`/`y`/`active_pixels` for a full pixel period. `VGA_HS`/`VGA_VS`/`VGA_BLANK_N` are registered together with `x`/`y` and stay aligned with them.
- **Simultaneous wrap:** at (H_TOTAL-1, V_TOTAL-1) the next `pix_en` goes to (0,0) in a single edge. `frame_tick` stays low on that edge.
- **`frame_tick` to next active video:** 45 lines (72000 `clk`). Game logic must finish its update within that window.

## Test plan
1. **Reset:** hold `rst_n` = 0 for 5 cycles → `x` = 0, `y` = 0, `active_pixels` = 0, `VGA_HS` = 1, `VGA_VS` = 1, `frame_tick` = 0. Release `rst_n` → first `pix_en` on `clk` edge 2 with `x` = 0, `y` = 0, `active_pixels` = 1.
2. **Horizontal timing:** over one line → `VGA_HS` low for exactly 96 pixels (192 `clk`) starting at `x` = 656; `active_pixels` high for `x` 0..639 only; `x` wraps 799 → 0 and `y` increments on the same edge.
3. **Vertical timing:** over one full frame → `VGA_VS` low only for `y` = 490 and 491 (3200 `clk`); `y` wraps 524 → 0; frame length is 840000 `clk`.
4. **Frame tick:** run 3 frames → exactly 3 `frame_tick` pulses, each one `clk` wide, each on the edge where `x` = 0 and `y` = 480, spaced 840000 `clk` apart.
5. **Mid-frame reset:** assert `rst_n` = 0 at `x` = 300, `y` = 200 → outputs take reset values immediately without waiting for a clock. After release → next frame starts at (0,0) after 2 `clk`.
6. **`VGA_CLK` phase:** check relative to `x` changes → `VGA_CLK` rises exactly 1 `clk` after each `x` change and falls on the `x` change edge.
